// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: holds one decoded instruction, waits for valid sources, issues to execute.
// Optional stall watchdog enabled by defining OPFETCH_STALL_WATCHDOG_EN.
//
// state   | meaning
// IDLE    | empty, may accept a decoded instruction
// WAIT    | instruction held, waiting for source registers to become valid
// ISSUE   | operands captured, ex_valid high until execute accepts
module operand_fetch_stage #(
    parameter int NUM_REGS       = 32,
    parameter int REG_ID_W       = $clog2(NUM_REGS),
    parameter int VEC_W          = 256,
    parameter int OPC_W          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dec_valid,
    output logic                dec_ready,
    input  logic [OPC_W-1:0]    dec_opcode,
    input  logic [REG_ID_W-1:0] dec_src_a,
    input  logic [REG_ID_W-1:0] dec_src_b,
    input  logic                dec_use_a,
    input  logic                dec_use_b,
    input  logic [REG_ID_W-1:0] dec_dst,
    input  logic                dec_use_dst,
    output logic [REG_ID_W-1:0] rf_rd_a_id,
    output logic [REG_ID_W-1:0] rf_rd_b_id,
    input  logic                rf_a_valid,
    input  logic                rf_b_valid,
    input  logic [VEC_W-1:0]    rf_a_data,
    input  logic [VEC_W-1:0]    rf_b_data,
    output logic                rf_inv_en,
    output logic [REG_ID_W-1:0] rf_inv_id,
    input  logic                rf_halted,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [OPC_W-1:0]    ex_opcode,
    output logic [VEC_W-1:0]    ex_op_a,
    output logic [VEC_W-1:0]    ex_op_b,
    output logic [REG_ID_W-1:0] ex_dst,
    output logic                ex_wr_dst,
    output logic                stall_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

    state_t              st;
    logic [OPC_W-1:0]    opc_q;
    logic [REG_ID_W-1:0] src_a_q;
    logic [REG_ID_W-1:0] src_b_q;
    logic [REG_ID_W-1:0] dst_q;
    logic                use_a_q;
    logic                use_b_q;
    logic                use_dst_q;

    logic ok_a;
    logic ok_b;
    logic fire;
    logic accept;

    assign ok_a   = !use_a_q || rf_a_valid;
    assign ok_b   = !use_b_q || rf_b_valid;
    assign fire   = (st == S_WAIT) && ok_a && ok_b;
    assign accept = dec_valid && dec_ready;

    always_comb begin
        dec_ready = 1'b0;
        case (st)
            S_IDLE:  dec_ready = !rf_halted;
            S_ISSUE: dec_ready = ex_ready && !rf_halted;
            default: dec_ready = 1'b0;
        endcase
    end

    assign rf_rd_a_id = src_a_q;
    assign rf_rd_b_id = src_b_q;

    // Invalidate on the capture edge so a src==dst instruction still reads the old value.
    assign rf_inv_en = fire && use_dst_q;
    assign rf_inv_id = dst_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_IDLE;
            opc_q     <= '0;
            src_a_q   <= '0;
            src_b_q   <= '0;
            dst_q     <= '0;
            use_a_q   <= 1'b0;
            use_b_q   <= 1'b0;
            use_dst_q <= 1'b0;
            ex_valid  <= 1'b0;
            ex_opcode <= '0;
            ex_op_a   <= '0;
            ex_op_b   <= '0;
            ex_dst    <= '0;
            ex_wr_dst <= 1'b0;
        end else begin
            if (accept) begin
                opc_q     <= dec_opcode;
                src_a_q   <= dec_src_a;
                src_b_q   <= dec_src_b;
                dst_q     <= dec_dst;
                use_a_q   <= dec_use_a;
                use_b_q   <= dec_use_b;
                use_dst_q <= dec_use_dst;
            end
            case (st)
                S_IDLE: begin
                    if (accept) st <= S_WAIT;
                end
                S_WAIT: begin
                    if (ok_a && ok_b) begin
                        ex_op_a   <= use_a_q ? rf_a_data : '0;
                        ex_op_b   <= use_b_q ? rf_b_data : '0;
                        ex_opcode <= opc_q;
                        ex_dst    <= dst_q;
                        ex_wr_dst <= use_dst_q;
                        ex_valid  <= 1'b1;
                        st        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ex_ready) begin
                        ex_valid <= 1'b0;
                        st       <= accept ? S_WAIT : S_IDLE;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

`ifdef OPFETCH_STALL_WATCHDOG_EN
    logic [15:0] stall_cnt;

    // Flag only; the stalled instruction keeps waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else if (st == S_WAIT) begin
            if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (32'(stall_cnt) + 32'd1 >= 32'(TIMEOUT_CYCLES)) stall_timeout <= 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end
`else
    assign stall_timeout = 1'b0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        assert (TIMEOUT_CYCLES > 0 && TIMEOUT_CYCLES <= 65535);
        if (st != S_IDLE) begin
            if (use_a_q) assert (int'(src_a_q) < NUM_REGS);
            if (use_b_q) assert (int'(src_b_q) < NUM_REGS);
            if (use_dst_q) assert (int'(dst_q) < NUM_REGS);
        end
    end
`endif

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Pipeline stage between instruction decode and execute in the vector core.
- Holds one decoded instruction and reads source operands from the register file.
- Stalls until the register-file scoreboard reports every needed source as valid (written count == invalidated count).
- Issues the instruction with captured vector operands to execute, and marks the destination register invalid at issue time.

Parameters:
NUM_REGS, 32, number of architectural vector registers (MAX_REG_ID)
REG_ID_W, 5, register id width, $clog2(NUM_REGS)
VEC_W, 256, width of one VectorValue
OPC_W, 8, opcode width
TIMEOUT_CYCLES, 1024, stall watchdog limit (optional feature only)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
dec_valid  in  1  decode has an instruction
dec_ready  out  1  stage accepts instruction this cycle
dec_opcode  in  OPC_W  opcode
dec_src_a / dec_src_b  in  REG_ID_W  source register ids
dec_use_a / dec_use_b  in  1  source is read
dec_dst  in  REG_ID_W  destination id
dec_use_dst  in  1  instruction writes dst
rf_rd_a_id / rf_rd_b_id  out  REG_ID_W  register-file read ids
rf_a_valid / rf_b_valid  in  1  register-file is_valid() for each read id
rf_a_data / rf_b_data  in  VEC_W  register-file get() data (combinational)
rf_inv_en  out  1  one-cycle mark_invalid request
rf_inv_id  out  REG_ID_W  register to invalidate
rf_halted  in  1  register-file hasHalted()
ex_valid  out  1  operands ready for execute
ex_ready  in  1  execute accepts
ex_opcode  out  OPC_W  opcode
ex_op_a / ex_op_b  out  VEC_W  captured operands
ex_dst  out  REG_ID_W  destination
ex_wr_dst  out  1  copy of use_dst
stall_timeout  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n). All state registers clear asynchronously on rst_n low.
- Reset values: state=IDLE; ex_valid=0; rf_inv_en=0; all data outputs 0; stall_timeout=0.
- Reset mid-operation: the held instruction is discarded and no rf_inv_en is issued.
- FSM states: IDLE, WAIT, ISSUE.
- IDLE:
  - dec_ready = !rf_halted.
  - On dec_valid && dec_ready: latch opcode, ids and use bits, then go to WAIT.
- WAIT:
  - rf_rd_*_id are driven from the latched ids.
  - ok_a = !use_a || rf_a_valid; ok_b = !use_b || rf_b_valid.
  - When ok_a && ok_b:
    - capture rf_*_data into ex_op_* (unused source captures 0);
    - pulse rf_inv_en=use_dst with rf_inv_id=dst for exactly that cycle;
    - go to ISSUE.
  - Otherwise hold. dec_ready=0.
- ISSUE:
  - ex_valid=1; outputs stable until ex_valid && ex_ready.
  - dec_ready = ex_ready && !rf_halted.
  - On handshake with a new decode: latch it and go to WAIT. Otherwise go to IDLE.
- Latency: acceptance at cycle N gives operand capture at N+1 at the earliest and ex_valid at N+2. Throughput is one instruction per 2 cycles.
- Source equal to destination: operands are captured before the invalidation takes effect (same edge), so the old value is read with no deadlock.
- Because of the 2-cycle spacing, the register file's registered invalidate is visible before the next instruction's check.
- Halt: rf_halted blocks new acceptance only. An instruction already in WAIT or ISSUE completes normally.
- ex_ready low in ISSUE: hold all outputs and do not re-pulse rf_inv_en.
- Id range: any latched id >= NUM_REGS with its use bit set fires a simulation assertion. It has no hardware effect.

Optional Feature:
- Macro: OPFETCH_STALL_WATCHDOG_EN.
- When defined:
  - a 16-bit counter increments on every cycle in WAIT and clears on leaving WAIT;
  - when the count reaches TIMEOUT_CYCLES, stall_timeout sets and stays set until reset;
  - the stall does not abort.
- When undefined: stall_timeout is tied 0 and the counter is absent.

Test Plan:
- Reset then dec_valid with src_a=3, src_b=4, dst=5, rf_a_valid=rf_b_valid=1, a_data=0xAA.., b_data=0x55.. → rf_inv_en pulse (id 5) at N+1; ex_valid at N+2 with ex_op_a=0xAA.., ex_op_b=0x55...
- rf_b_valid held low 10 cycles → stays WAIT, no rf_inv_en, dec_ready=0. b_valid goes high at cycle 10 → capture next edge, ex_valid one cycle later.
- use_a=1, use_b=0, src_a=dst=7, a_data=0x11.. → ex_op_a=0x11.., ex_op_b=0, exactly one rf_inv_en with id 7.
- ex_ready low 5 cycles in ISSUE with a second instruction waiting → outputs stable, single rf_inv_en. When ex_ready rises, the second instruction is accepted in the same cycle.
- rf_halted=1 while in WAIT → the instruction issues, then dec_ready stays 0 and no acceptance occurs. Asserting rst_n=0 in WAIT → ex_valid=0 immediately and no rf_inv_en.
- With OPFETCH_STALL_WATCHDOG_EN and TIMEOUT_CYCLES=16, rf_a_valid low 20 cycles → stall_timeout=1 from cycle 16 and it remains set after the instruction issues.
